// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared encodings and address-decode helpers for the AXI-Lite memory responder
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int WORD_LSB = 2;
  localparam int CNT_W    = 2;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_COLLECT = 2'd1,
    WR_RESP    = 2'd2
  } wr_state_e;

  // A byte offset from the window base is usable only if word aligned and inside the RAM.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] off,
                                      input logic [31:0] depth_words);
    return (off[WORD_LSB-1:0] == 2'b00) &&
           ({2'b00, off[ADDR_W-1:WORD_LSB]} < depth_words);
  endfunction

endpackage

// File: rtl/axi_lite_ram.sv
// rtl/axi_lite_ram.sv - DEPTH x 32 RAM, synchronous write, registered read-before-write read port
module axi_lite_ram
  import axi_lite_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rzero,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never cleared; a write lands on the same edge it is requested.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register samples the pre-write contents, so a same-edge collision returns old data;
  // rzero forces zero for rejected accesses and the value holds while re is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rzero ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// rtl/axi_lite_mem_slave.sv - AXI4-Lite-style memory responder with independent read and write FSMs
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int          DEPTH        = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP
);

  localparam int IDX_W = $clog2(DEPTH);

  // ---------------- read path ----------------
  rd_state_e         rd_state, rd_next;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [31:0]       ar_addr_q;
  logic [1:0]        rresp_q;
  logic [31:0]       rd_off;
  logic              rd_ok;
  logic              rd_sample;
  logic              ar_hs;

  assign ar_hs     = ARVALID && ARREADY;
  assign rd_off    = ar_addr_q - BASE_ADDR;
  assign rd_ok     = addr_valid(rd_off, 32'(DEPTH));
  // The edge that moves WAIT into RESP is the edge that samples the RAM.
  assign rd_sample = (rd_state == RD_WAIT) && (rd_cnt_q == '0);

  // Read next-state: every accepted address passes through WAIT so RVALID lands READ_LATENCY edges later.
  always_comb begin
    rd_next  = rd_state;
    rd_cnt_d = rd_cnt_q;
    case (rd_state)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_next  = RD_WAIT;
          rd_cnt_d = CNT_W'(READ_LATENCY - 1);
        end
      end
      RD_WAIT: begin
        if (rd_cnt_q == '0) begin
          rd_next = RD_RESP;
        end else begin
          rd_cnt_d = rd_cnt_q - 1'b1;
        end
      end
      RD_RESP: begin
        if (RREADY) begin
          rd_next = RD_IDLE;
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // Read state, latency counter, captured address and response code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= RD_IDLE;
      rd_cnt_q  <= '0;
      ar_addr_q <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      rd_cnt_q <= rd_cnt_d;
      if (ar_hs) begin
        ar_addr_q <= ARADDR;
      end
      if (rd_sample) begin
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign ARREADY = (rd_state == RD_IDLE);
  assign RVALID  = (rd_state == RD_RESP);
  assign RRESP   = rresp_q;

  // ---------------- write path ----------------
  wr_state_e   wr_state, wr_next;
  logic        aw_got_q, w_got_q;
  logic [31:0] aw_addr_q, wdata_q;
  logic [1:0]  bresp_q;
  logic        aw_hs, w_hs;
  logic        wr_commit;
  logic [31:0] wr_addr_sel, wr_data_sel, wr_off;
  logic        wr_ok;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;

  // Commit either on a same-cycle AW+W handshake out of IDLE, or the cycle after both were captured.
  assign wr_commit   = ((wr_state == WR_IDLE) && aw_hs && w_hs) ||
                       ((wr_state == WR_COLLECT) && aw_got_q && w_got_q);
  assign wr_addr_sel = (wr_state == WR_IDLE) ? AWADDR : aw_addr_q;
  assign wr_data_sel = (wr_state == WR_IDLE) ? WDATA : wdata_q;
  assign wr_off      = wr_addr_sel - BASE_ADDR;
  assign wr_ok       = addr_valid(wr_off, 32'(DEPTH));

  // Write next-state: gather AW and W in any order, then hold the response until BREADY.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_next = WR_RESP;
        end else if (aw_hs || w_hs) begin
          wr_next = WR_COLLECT;
        end
      end
      WR_COLLECT: begin
        if (aw_got_q && w_got_q) begin
          wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          wr_next = WR_IDLE;
        end
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // Write state, capture flags and payloads, and the latched response code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state  <= WR_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) begin
        aw_got_q  <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_hs) begin
        w_got_q <= 1'b1;
        wdata_q <= WDATA;
      end
      if (wr_commit) begin
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign AWREADY = (wr_state == WR_IDLE) || ((wr_state == WR_COLLECT) && !aw_got_q);
  assign WREADY  = (wr_state == WR_IDLE) || ((wr_state == WR_COLLECT) && !w_got_q);
  assign BVALID  = (wr_state == WR_RESP);
  assign BRESP   = bresp_q;

  axi_lite_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_commit && wr_ok),
    .waddr (wr_off[WORD_LSB +: IDX_W]),
    .wdata (wr_data_sel),
    .re    (rd_sample),
    .rzero (!rd_ok),
    .raddr (rd_off[WORD_LSB +: IDX_W]),
    .rdata (RDATA)
  );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb/tb_axi_lite_mem_slave.sv - self-checking bench for axi_lite_mem_slave
module tb_axi_lite_mem_slave;
  import axi_lite_pkg::*;

  localparam int TMO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] araddr [2];
  logic [31:0] rdata  [2];
  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [1:0]  rresp  [2];
  logic [1:0]  bresp  [2];

  int n_chk  = 0;
  int n_pass = 0;

  logic [33:0] rd_q [$];
  logic [1:0]  wr_q [$];

  axi_lite_mem_slave #(.DEPTH(32), .BASE_ADDR(32'h0000_0000), .READ_LATENCY(1)) u_dut_rl1 (
    .clk(clk), .rst_n(rst_n),
    .ARVALID(arvalid[0]), .ARREADY(arready[0]), .ARADDR(araddr[0]),
    .RVALID(rvalid[0]), .RREADY(rready[0]), .RDATA(rdata[0]), .RRESP(rresp[0]),
    .AWVALID(awvalid[0]), .AWREADY(awready[0]), .AWADDR(awaddr[0]),
    .WVALID(wvalid[0]), .WREADY(wready[0]), .WDATA(wdata[0]),
    .BVALID(bvalid[0]), .BREADY(bready[0]), .BRESP(bresp[0])
  );

  axi_lite_mem_slave #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .READ_LATENCY(3)) u_dut_rl3 (
    .clk(clk), .rst_n(rst_n),
    .ARVALID(arvalid[1]), .ARREADY(arready[1]), .ARADDR(araddr[1]),
    .RVALID(rvalid[1]), .RREADY(rready[1]), .RDATA(rdata[1]), .RRESP(rresp[1]),
    .AWVALID(awvalid[1]), .AWREADY(awready[1]), .AWADDR(awaddr[1]),
    .WVALID(wvalid[1]), .WREADY(wready[1]), .WDATA(wdata[1]),
    .BVALID(bvalid[1]), .BREADY(bready[1]), .BRESP(bresp[1])
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    $display("FAIL %s: no response within %0d cycles", name, TMO);
  endtask

  task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    awvalid[k] = 1'b1; awaddr[k] = addr; wvalid[k] = 1'b1; wdata[k] = data; bready[k] = 1'b1;
    wr_q.push_back(resp);
    @(posedge clk); #1;
    awvalid[k] = 1'b0; wvalid[k] = 1'b0;
    n = 0;
    while (!bvalid[k] && n < TMO) begin @(posedge clk); #1; n++; end
    if (!bvalid[k]) timeout_fail("bvalid_wait");
    else chk("aw_w_to_bvalid_edges", n, 0);
    chk("bresp", bresp[k], wr_q.pop_front());
    @(posedge clk); #1;
    bready[k] = 1'b0;
    chk("bvalid_awready_wready_after_b", {bvalid[k], awready[k], wready[k]}, 3'b011);
  endtask

  task automatic do_read(input int k, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int lat);
    int n;
    logic [33:0] e;
    @(posedge clk); #1;
    arvalid[k] = 1'b1; araddr[k] = addr; rready[k] = 1'b1;
    rd_q.push_back({exp_resp, exp_data});
    @(posedge clk); #1;
    arvalid[k] = 1'b0;
    chk("arready_after_ar", arready[k], 0);
    n = 0;
    while (!rvalid[k] && n < TMO) begin @(posedge clk); #1; n++; end
    if (!rvalid[k]) timeout_fail("rvalid_wait");
    else chk("ar_to_rvalid_edges", n, lat);
    e = rd_q.pop_front();
    chk("rdata", rdata[k], e[31:0]);
    chk("rresp", rresp[k], e[33:32]);
    @(posedge clk); #1;
    rready[k] = 1'b0;
    chk("rvalid_arready_after_r", {rvalid[k], arready[k]}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [33:0] e;

    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, RESP_OKAY};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, RESP_OKAY};
    tbl[2]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0001, RESP_OKAY};
    tbl[3]  = '{1'b1, 32'h0000_007C, 32'h0000_7777, RESP_OKAY};
    tbl[4]  = '{1'b0, 32'h0000_007C, 32'h0000_7777, RESP_OKAY};
    tbl[5]  = '{1'b0, 32'h0000_0080, 32'h0000_0000, RESP_SLVERR};
    tbl[6]  = '{1'b1, 32'h0000_0002, 32'h0000_0BAD, RESP_SLVERR};
    tbl[7]  = '{1'b0, 32'h0000_0000, 32'hA5A5_0001, RESP_OKAY};
    tbl[8]  = '{1'b1, 32'h0000_0080, 32'h0000_0BAD, RESP_SLVERR};
    tbl[9]  = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, RESP_SLVERR};
    tbl[10] = '{1'b0, 32'h0000_0001, 32'h0000_0000, RESP_SLVERR};

    rst_n = 1'b0;
    arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
    for (int i = 0; i < 2; i++) begin
      araddr[i] = '0; awaddr[i] = '0; wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_readies", {arready[0], awready[0], wready[0]}, 3'b111);
    chk("reset_valids", {rvalid[0], bvalid[0]}, 2'b00);
    chk("reset_rdata", rdata[0], 32'h0);
    chk("reset_resps", {rresp[0], bresp[0]}, 4'b0000);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].is_wr) do_write(0, tbl[i].addr, tbl[i].data, tbl[i].exp_resp);
      else do_read(0, tbl[i].addr, tbl[i].data, tbl[i].exp_resp, 1);
    end

    // W arrives three edges before AW; commit waits for AW.
    @(posedge clk); #1;
    wvalid[0] = 1'b1; wdata[0] = 32'h0000_1234; bready[0] = 1'b1;
    wr_q.push_back(RESP_OKAY);
    @(posedge clk); #1;
    wvalid[0] = 1'b0;
    chk("collect_w_first_ready", {awready[0], wready[0], bvalid[0]}, 3'b100);
    repeat (2) @(posedge clk);
    #1;
    chk("collect_hold_ready", {awready[0], wready[0], bvalid[0]}, 3'b100);
    awvalid[0] = 1'b1; awaddr[0] = 32'h0000_0004;
    @(posedge clk); #1;
    awvalid[0] = 1'b0;
    chk("collect_no_early_commit", bvalid[0], 0);
    @(posedge clk); #1;
    chk("collect_commit_bvalid", bvalid[0], 1);
    chk("collect_bresp", bresp[0], wr_q.pop_front());
    @(posedge clk); #1;
    bready[0] = 1'b0;
    chk("collect_readies_back", {awready[0], wready[0]}, 2'b11);
    do_read(0, 32'h0000_0004, 32'h0000_1234, RESP_OKAY, 1);

    // Commit and read sample on the same edge: old data first, new data after.
    do_write(0, 32'h0000_0008, 32'h0000_0001, RESP_OKAY);
    @(posedge clk); #1;
    arvalid[0] = 1'b1; araddr[0] = 32'h0000_0008; rready[0] = 1'b0;
    rd_q.push_back({RESP_OKAY, 32'h0000_0001});
    @(posedge clk); #1;
    arvalid[0] = 1'b0;
    awvalid[0] = 1'b1; awaddr[0] = 32'h0000_0008; wvalid[0] = 1'b1; wdata[0] = 32'h0000_0002;
    bready[0] = 1'b1;
    wr_q.push_back(RESP_OKAY);
    @(posedge clk); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    chk("collision_rvalid_bvalid", {rvalid[0], bvalid[0]}, 2'b11);
    e = rd_q.pop_front();
    chk("collision_old_rdata", rdata[0], e[31:0]);
    chk("collision_bresp", bresp[0], wr_q.pop_front());
    rready[0] = 1'b1;
    @(posedge clk); #1;
    rready[0] = 1'b0; bready[0] = 1'b0;
    do_read(0, 32'h0000_0008, 32'h0000_0002, RESP_OKAY, 1);

    // READ_LATENCY=3 instance with a stalled R channel.
    do_write(1, 32'h0000_1020, 32'hCAFE_F00D, RESP_OKAY);
    @(posedge clk); #1;
    arvalid[1] = 1'b1; araddr[1] = 32'h0000_1020; rready[1] = 1'b0;
    rd_q.push_back({RESP_OKAY, 32'hCAFE_F00D});
    @(posedge clk); #1;
    arvalid[1] = 1'b0;
    n = 0;
    while (!rvalid[1] && n < TMO) begin @(posedge clk); #1; n++; end
    if (!rvalid[1]) timeout_fail("rl3_rvalid_wait");
    else chk("rl3_ar_to_rvalid_edges", n, 3);
    e = rd_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      chk("rl3_stall_rdata", rdata[1], e[31:0]);
      chk("rl3_stall_rvalid_arready", {rvalid[1], arready[1]}, 2'b10);
      @(posedge clk); #1;
    end
    chk("rl3_rresp", rresp[1], e[33:32]);
    rready[1] = 1'b1;
    @(posedge clk); #1;
    rready[1] = 1'b0;
    chk("rl3_after_r", {rvalid[1], arready[1]}, 2'b01);
    do_read(1, 32'h0000_0FFC, 32'h0, RESP_SLVERR, 3);
    do_read(1, 32'h0000_1040, 32'h0, RESP_SLVERR, 3);

    // Reset while AW is captured and W is still pending.
    do_write(0, 32'h0000_000C, 32'h0000_0055, RESP_OKAY);
    @(posedge clk); #1;
    awvalid[0] = 1'b1; awaddr[0] = 32'h0000_000C;
    @(posedge clk); #1;
    awvalid[0] = 1'b0;
    chk("pre_reset_collect", {awready[0], wready[0]}, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", {bvalid[0], awready[0], wready[0]}, 3'b011);
    chk("async_reset_rdata", rdata[0], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(0, 32'h0000_000C, 32'h0000_0055, RESP_OKAY, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
